// File: rtl/ps2_matrix.sv
// ps2_matrix: PS/2 keyboard receiver and set-2 scancode decoder that maintains
// the 8x5 ZX Spectrum key matrix and presents active-low half-row column data.
// Optional build macro: PS2_PARITY_CHECK_EN. When it is defined, odd parity is
// checked and a bad frame is dropped. When it is not defined, the parity bit is
// sampled and ignored.
module ps2_matrix #(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 28000
) (
  input  logic       clk28,
  input  logic       rst,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  input  logic [7:0] addr,
  output logic [4:0] kd,
  output logic       key_magic,
  output logic       key_reset,
  output logic       frame_err
);

  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DATA,
    S_PARITY,
    S_STOP
  } rx_state_t;

  // Key descriptor: {hit, row[2:0], col[2:0]}
  function automatic logic [6:0] km(input logic [2:0] row, input logic [2:0] col);
    km = {1'b1, row, col};
  endfunction

  logic [1:0]            r_clk_sync;
  logic [1:0]            r_dat_sync;
  logic [FILTER_LEN-1:0] r_clk_hist;
  logic                  r_clk_filt;
  logic                  w_fall;
  logic                  w_dat;

  rx_state_t             r_state;
  rx_state_t             w_state_next;
  logic [2:0]            r_bit_cnt;
  logic [7:0]            r_shift;
  logic [TO_W-1:0]       r_to_cnt;
  logic                  w_timeout;
  logic                  w_rx_err;
  logic                  w_byte_done;
  logic                  w_par_ok;
  logic [7:0]            r_rx_byte;
  logic                  r_rx_valid;
  logic                  r_frame_err;

  logic                  r_ext;
  logic                  r_brk;
  logic                  w_apply;
  logic [6:0]            w_key0;
  logic [6:0]            w_key1;
  logic                  w_is_ctrl;
  logic                  w_is_alt;
  logic                  w_is_del;
  logic                  w_is_f12;
  logic                  r_ctrl_held;
  logic                  r_alt_held;
  logic                  r_magic;
  logic                  r_reset_req;

  logic [4:0]            r_matrix [8];
  logic [4:0]            w_mask [8];
  logic [4:0]            w_row_sel [8];
  logic [4:0]            w_or;
  logic [4:0]            r_kd;

  // Two-flop synchronisers for both asynchronous PS/2 pins (idle level is high)
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_clk_sync <= 2'b11;
      r_dat_sync <= 2'b11;
    end else begin
      r_clk_sync <= {r_clk_sync[0], ps2_clk};
      r_dat_sync <= {r_dat_sync[0], ps2_dat};
    end
  end

  // Glitch filter: filtered clock only changes once the whole history agrees
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_clk_hist <= '1;
      r_clk_filt <= 1'b1;
    end else begin
      r_clk_hist <= {r_clk_hist[FILTER_LEN-2:0], r_clk_sync[1]};
      if (&r_clk_hist) begin
        r_clk_filt <= 1'b1;
      end else if (~|r_clk_hist) begin
        r_clk_filt <= 1'b0;
      end
    end
  end

  // The falling edge is seen in the single cycle where the history is all low
  // but the filtered level has not yet followed.
  assign w_fall = r_clk_filt & ~|r_clk_hist;
  assign w_dat  = r_dat_sync[1];

  // A timeout only counts when no edge arrives in the same cycle.
  assign w_timeout = (r_state != S_IDLE) && !w_fall &&
                     (r_to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

`ifdef PS2_PARITY_CHECK_EN
  assign w_par_ok = ^{r_shift, w_dat};
`else
  assign w_par_ok = 1'b1;
`endif

  // Receiver state register
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Receiver next-state logic, frame error and byte completion
  always_comb begin
    w_state_next = r_state;
    w_rx_err     = 1'b0;
    w_byte_done  = 1'b0;
    if (w_timeout) begin
      w_state_next = S_IDLE;
      w_rx_err     = 1'b1;
    end else if (w_fall) begin
      case (r_state)
        S_IDLE: begin
          if (!w_dat) begin
            w_state_next = S_DATA;
          end
        end
        S_DATA: begin
          if (r_bit_cnt == 3'd7) begin
            w_state_next = S_PARITY;
          end
        end
        S_PARITY: begin
          if (w_par_ok) begin
            w_state_next = S_STOP;
          end else begin
            w_state_next = S_IDLE;
            w_rx_err     = 1'b1;
          end
        end
        S_STOP: begin
          w_state_next = S_IDLE;
          if (w_dat) begin
            w_byte_done = 1'b1;
          end else begin
            w_rx_err = 1'b1;
          end
        end
        default: w_state_next = S_IDLE;
      endcase
    end
  end

  // Receiver datapath: bit shifting, idle timer, received byte, and error pulse
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_bit_cnt   <= '0;
      r_shift     <= '0;
      r_to_cnt    <= '0;
      r_rx_byte   <= '0;
      r_rx_valid  <= 1'b0;
      r_frame_err <= 1'b0;
    end else begin
      if (w_fall || r_state == S_IDLE) begin
        r_to_cnt <= '0;
      end else if (!w_timeout) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (w_fall && r_state == S_IDLE) begin
        r_bit_cnt <= '0;
      end
      if (w_fall && r_state == S_DATA) begin
        r_shift   <= {w_dat, r_shift[7:1]};
        r_bit_cnt <= r_bit_cnt + 1'b1;
      end
      r_rx_valid  <= w_byte_done;
      if (w_byte_done) begin
        r_rx_byte <= r_shift;
      end
      r_frame_err <= w_rx_err;
    end
  end

  assign w_apply = r_rx_valid && (r_rx_byte != 8'hE0) && (r_rx_byte != 8'hF0);

  // Scancode lookup. w_key1 is the second bit for composite keys; CS is key0.
  always_comb begin
    w_key0 = 7'd0;
    w_key1 = 7'd0;
    case ({r_ext, r_rx_byte})
      9'h012, 9'h059: w_key0 = km(3'd0, 3'd0);
      9'h01A:         w_key0 = km(3'd0, 3'd1);
      9'h022:         w_key0 = km(3'd0, 3'd2);
      9'h021:         w_key0 = km(3'd0, 3'd3);
      9'h02A:         w_key0 = km(3'd0, 3'd4);
      9'h01C:         w_key0 = km(3'd1, 3'd0);
      9'h01B:         w_key0 = km(3'd1, 3'd1);
      9'h023:         w_key0 = km(3'd1, 3'd2);
      9'h02B:         w_key0 = km(3'd1, 3'd3);
      9'h034:         w_key0 = km(3'd1, 3'd4);
      9'h015:         w_key0 = km(3'd2, 3'd0);
      9'h01D:         w_key0 = km(3'd2, 3'd1);
      9'h024:         w_key0 = km(3'd2, 3'd2);
      9'h02D:         w_key0 = km(3'd2, 3'd3);
      9'h02C:         w_key0 = km(3'd2, 3'd4);
      9'h016:         w_key0 = km(3'd3, 3'd0);
      9'h01E:         w_key0 = km(3'd3, 3'd1);
      9'h026:         w_key0 = km(3'd3, 3'd2);
      9'h025:         w_key0 = km(3'd3, 3'd3);
      9'h02E:         w_key0 = km(3'd3, 3'd4);
      9'h045:         w_key0 = km(3'd4, 3'd0);
      9'h046:         w_key0 = km(3'd4, 3'd1);
      9'h03E:         w_key0 = km(3'd4, 3'd2);
      9'h03D:         w_key0 = km(3'd4, 3'd3);
      9'h036:         w_key0 = km(3'd4, 3'd4);
      9'h04D:         w_key0 = km(3'd5, 3'd0);
      9'h044:         w_key0 = km(3'd5, 3'd1);
      9'h043:         w_key0 = km(3'd5, 3'd2);
      9'h03C:         w_key0 = km(3'd5, 3'd3);
      9'h035:         w_key0 = km(3'd5, 3'd4);
      9'h05A, 9'h15A: w_key0 = km(3'd6, 3'd0);
      9'h04B:         w_key0 = km(3'd6, 3'd1);
      9'h042:         w_key0 = km(3'd6, 3'd2);
      9'h03B:         w_key0 = km(3'd6, 3'd3);
      9'h033:         w_key0 = km(3'd6, 3'd4);
      9'h029:         w_key0 = km(3'd7, 3'd0);
      9'h014, 9'h114: w_key0 = km(3'd7, 3'd1);
      9'h03A:         w_key0 = km(3'd7, 3'd2);
      9'h031:         w_key0 = km(3'd7, 3'd3);
      9'h032:         w_key0 = km(3'd7, 3'd4);
      // Backspace = CS+0, arrows = CS+7/6/5/8
      9'h066: begin w_key0 = km(3'd0, 3'd0); w_key1 = km(3'd4, 3'd0); end
      9'h175: begin w_key0 = km(3'd0, 3'd0); w_key1 = km(3'd4, 3'd3); end
      9'h172: begin w_key0 = km(3'd0, 3'd0); w_key1 = km(3'd4, 3'd4); end
      9'h16B: begin w_key0 = km(3'd0, 3'd0); w_key1 = km(3'd3, 3'd4); end
      9'h174: begin w_key0 = km(3'd0, 3'd0); w_key1 = km(3'd4, 3'd2); end
      default: begin
        w_key0 = 7'd0;
        w_key1 = 7'd0;
      end
    endcase
  end

  // Left and right Ctrl/Alt share one held flag each.
  assign w_is_ctrl = (r_rx_byte == 8'h14);
  assign w_is_alt  = (r_rx_byte == 8'h11);
  assign w_is_del  = r_ext && (r_rx_byte == 8'h71);
  assign w_is_f12  = !r_ext && (r_rx_byte == 8'h07);

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_row
      // Per-row bit mask touched by the decoded key(s)
      assign w_mask[gi] =
        ((w_key0[6] && w_key0[5:3] == 3'(gi)) ? (5'b00001 << w_key0[2:0]) : 5'b00000) |
        ((w_key1[6] && w_key1[5:3] == 3'(gi)) ? (5'b00001 << w_key1[2:0]) : 5'b00000);
      // A row contributes only when its address line is low
      assign w_row_sel[gi] = addr[gi] ? 5'b00000 : r_matrix[gi];
    end
  endgenerate

  // Prefix flags, modifier tracking, and one-shot magic/reset requests
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_ext       <= 1'b0;
      r_brk       <= 1'b0;
      r_ctrl_held <= 1'b0;
      r_alt_held  <= 1'b0;
      r_magic     <= 1'b0;
      r_reset_req <= 1'b0;
    end else begin
      r_magic     <= w_apply && w_is_f12 && !r_brk;
      r_reset_req <= w_apply && w_is_del && !r_brk && r_ctrl_held && r_alt_held;
      if (r_rx_valid) begin
        if (r_rx_byte == 8'hE0) begin
          r_ext <= 1'b1;
        end else if (r_rx_byte == 8'hF0) begin
          r_brk <= 1'b1;
        end else begin
          r_ext <= 1'b0;
          r_brk <= 1'b0;
          if (w_is_ctrl) begin
            r_ctrl_held <= !r_brk;
          end
          if (w_is_alt) begin
            r_alt_held <= !r_brk;
          end
        end
      end
    end
  end

  // Key matrix: a make sets the key's bits and a break clears them. A break of
  // a composite key therefore also releases CS.
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        r_matrix[i] <= 5'b00000;
      end
    end else if (w_apply) begin
      for (int i = 0; i < 8; i++) begin
        r_matrix[i] <= r_brk ? (r_matrix[i] & ~w_mask[i]) : (r_matrix[i] | w_mask[i]);
      end
    end
  end

  // OR together every row whose address line is low
  always_comb begin
    w_or = 5'b00000;
    for (int i = 0; i < 8; i++) begin
      w_or = w_or | w_row_sel[i];
    end
  end

  // Registered active-low column data
  always_ff @(posedge clk28 or posedge rst) begin
    if (rst) begin
      r_kd <= 5'b11111;
    end else begin
      r_kd <= ~w_or;
    end
  end

  assign kd        = r_kd;
  assign key_magic = r_magic;
  assign key_reset = r_reset_req;
  assign frame_err = r_frame_err;

endmodule

// File: tb/tb_ps2_matrix.sv
// tb_ps2_matrix: directed bench for ps2_matrix. It drives PS/2 frames on the
// pins, then checks kd across address patterns and counts the one-shot pulses.
module tb_ps2_matrix;

  logic       clk28 = 1'b0;
  logic       rst;
  logic       ps2_clk;
  logic       ps2_dat;
  logic [7:0] addr;
  logic [4:0] kd;
  logic       key_magic;
  logic       key_reset;
  logic       frame_err;

  int n_checks = 0;
  int n_errors = 0;
  int n_magic  = 0;
  int n_reset  = 0;
  int n_ferr   = 0;

  ps2_matrix #(
    .FILTER_LEN     (8),
    .TIMEOUT_CYCLES (2000)
  ) dut (
    .clk28     (clk28),
    .rst       (rst),
    .ps2_clk   (ps2_clk),
    .ps2_dat   (ps2_dat),
    .addr      (addr),
    .kd        (kd),
    .key_magic (key_magic),
    .key_reset (key_reset),
    .frame_err (frame_err)
  );

  always #5 clk28 = ~clk28;

  // Count high cycles of each pulse output. A clean one-cycle pulse adds exactly 1.
  always @(negedge clk28) begin
    if (key_magic === 1'b1) n_magic++;
    if (key_reset === 1'b1) n_reset++;
    if (frame_err === 1'b1) n_ferr++;
  end

  task automatic clks(input int n);
    repeat (n) @(posedge clk28);
    #1;
  endtask

  task automatic ps2_bit(input logic b);
    ps2_dat = b;
    clks(20);
    ps2_clk = 1'b0;
    clks(20);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip, input int gap);
    logic par;
    par = ~(^b) ^ flip;
    ps2_bit(1'b0);
    for (int i = 0; i < 8; i++) ps2_bit(b[i]);
    ps2_bit(par);
    ps2_bit(1'b1);
    clks(gap);
  endtask

  task automatic key(input logic [7:0] b);
    send_byte(b, 1'b0, 40);
  endtask

  task automatic test_reset;
    rst = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1; addr = 8'h00;
    clks(5);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL reset_kd_in_reset: kd=%b expected 11111", kd); end
    rst = 1'b0;
    clks(3);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL reset_kd: kd=%b expected 11111", kd); end
    n_checks++;
    if ({key_magic, key_reset, frame_err} !== 3'b000) begin
      n_errors++; $display("FAIL reset_pulses: got %b expected 000", {key_magic, key_reset, frame_err});
    end
    $display("reset: kd=%b pulses=%b", kd, {key_magic, key_reset, frame_err});
  endtask

  task automatic test_single_key;
    logic [7:0] a_tab [6];
    logic [4:0] e_tab [6];
    a_tab = '{8'hFD, 8'hFE, 8'hFB, 8'h7F, 8'hFF, 8'h00};
    e_tab = '{5'b11110, 5'b11111, 5'b11111, 5'b11111, 5'b11111, 5'b11110};
    key(8'h1C);
    for (int i = 0; i < 6; i++) begin
      addr = a_tab[i]; clks(1);
      n_checks++;
      if (kd !== e_tab[i]) begin n_errors++; $display("FAIL single_A addr=%h: kd=%b expected %b", a_tab[i], kd, e_tab[i]); end
      $display("single A make: addr=%h kd=%b", addr, kd);
    end
    key(8'hF0); key(8'h1C);
    addr = 8'hFD; clks(1);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL single_A_break: kd=%b expected 11111", kd); end
    $display("single A break: addr=%h kd=%b", addr, kd);
  endtask

  task automatic test_two_keys;
    logic [7:0] a_tab [5];
    logic [4:0] e_tab [5];
    a_tab = '{8'h00, 8'hFB, 8'hFD, 8'h7F, 8'hF9};
    e_tab = '{5'b11110, 5'b11110, 5'b11110, 5'b11111, 5'b11110};
    key(8'h1C); key(8'h15);
    for (int i = 0; i < 5; i++) begin
      addr = a_tab[i]; clks(1);
      n_checks++;
      if (kd !== e_tab[i]) begin n_errors++; $display("FAIL two_keys addr=%h: kd=%b expected %b", a_tab[i], kd, e_tab[i]); end
      $display("A+Q held: addr=%h kd=%b", addr, kd);
    end
    key(8'hF0); key(8'h1C); key(8'hF0); key(8'h15);
    addr = 8'h00; clks(1);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL two_keys_release: kd=%b expected 11111", kd); end
  endtask

  task automatic test_composite;
    key(8'h66);
    addr = 8'hFE; clks(1);
    n_checks++;
    if (kd !== 5'b11110) begin n_errors++; $display("FAIL bksp_cs: kd=%b expected 11110", kd); end
    addr = 8'hEF; clks(1);
    n_checks++;
    if (kd !== 5'b11110) begin n_errors++; $display("FAIL bksp_0: kd=%b expected 11110", kd); end
    $display("backspace make: row0/row4 checked kd=%b", kd);
    key(8'hF0); key(8'h66);
    addr = 8'hEE; clks(1);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL bksp_break: kd=%b expected 11111", kd); end
    // Up arrow = CS + 7 (row4 bit3)
    key(8'hE0); key(8'h75);
    addr = 8'hEF; clks(1);
    n_checks++;
    if (kd !== 5'b10111) begin n_errors++; $display("FAIL up_7: kd=%b expected 10111", kd); end
    addr = 8'hFE; clks(1);
    n_checks++;
    if (kd !== 5'b11110) begin n_errors++; $display("FAIL up_cs: kd=%b expected 11110", kd); end
    key(8'hE0); key(8'hF0); key(8'h75);
    // Shift held, then Left arrow (CS + 5) made and broken: CS must drop
    key(8'h12); key(8'hE0); key(8'h6B);
    addr = 8'hF7; clks(1);
    n_checks++;
    if (kd !== 5'b01111) begin n_errors++; $display("FAIL left_5: kd=%b expected 01111", kd); end
    key(8'hE0); key(8'hF0); key(8'h6B);
    addr = 8'hFE; clks(1);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL composite_break_cs: kd=%b expected 11111", kd); end
    $display("left arrow break with shift held: kd=%b", kd);
    key(8'hF0); key(8'h12);
  endtask

  task automatic test_parity;
    int f0;
    f0 = n_ferr;
    send_byte(8'h1C, 1'b1, 40);
    addr = 8'hFD; clks(1);
`ifdef PS2_PARITY_CHECK_EN
    n_checks++;
    if (n_ferr !== f0 + 1) begin n_errors++; $display("FAIL parity_err: count=%0d expected %0d", n_ferr - f0, 1); end
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL parity_kd: kd=%b expected 11111", kd); end
`else
    n_checks++;
    if (n_ferr !== f0) begin n_errors++; $display("FAIL parity_err: count=%0d expected %0d", n_ferr - f0, 0); end
    n_checks++;
    if (kd !== 5'b11110) begin n_errors++; $display("FAIL parity_kd: kd=%b expected 11110", kd); end
`endif
    $display("bad parity 1C: kd=%b frame_err pulses=%0d", kd, n_ferr - f0);
    key(8'hF0); key(8'h1C);
  endtask

  task automatic test_timeout;
    int f0;
    f0 = n_ferr;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1);
    ps2_dat = 1'b1;
    clks(2400);
    n_checks++;
    if (n_ferr !== f0 + 1) begin n_errors++; $display("FAIL timeout_err: count=%0d expected 1", n_ferr - f0); end
    key(8'h29);
    addr = 8'h7F; clks(1);
    n_checks++;
    if (kd !== 5'b11110) begin n_errors++; $display("FAIL timeout_space: kd=%b expected 11110", kd); end
    n_checks++;
    if (n_ferr !== f0 + 1) begin n_errors++; $display("FAIL timeout_clean_frame: count=%0d expected 1", n_ferr - f0); end
    $display("timeout then space: kd=%b frame_err pulses=%0d", kd, n_ferr - f0);
    key(8'hF0); key(8'h29);
  endtask

  task automatic test_magic;
    int m0;
    m0 = n_magic;
    key(8'h07);
    n_checks++;
    if (n_magic !== m0 + 1) begin n_errors++; $display("FAIL magic_pulse: count=%0d expected 1", n_magic - m0); end
    key(8'h07);
    n_checks++;
    if (n_magic !== m0 + 2) begin n_errors++; $display("FAIL magic_repeat: count=%0d expected 2", n_magic - m0); end
    key(8'hF0); key(8'h07);
    n_checks++;
    if (n_magic !== m0 + 2) begin n_errors++; $display("FAIL magic_break: count=%0d expected 2", n_magic - m0); end
    $display("F12 x2 + break: magic pulses=%0d", n_magic - m0);
  endtask

  task automatic test_reset_combo;
    int r0;
    r0 = n_reset;
    key(8'h14); key(8'hE0); key(8'h71);
    n_checks++;
    if (n_reset !== r0) begin n_errors++; $display("FAIL reset_ctrl_only: count=%0d expected 0", n_reset - r0); end
    key(8'hE0); key(8'hF0); key(8'h71);
    key(8'h11); key(8'hE0); key(8'h71);
    n_checks++;
    if (n_reset !== r0 + 1) begin n_errors++; $display("FAIL reset_combo: count=%0d expected 1", n_reset - r0); end
    addr = 8'h7F; clks(1);
    n_checks++;
    if (kd !== 5'b11101) begin n_errors++; $display("FAIL ctrl_ss: kd=%b expected 11101", kd); end
    $display("ctrl+alt+del: reset pulses=%0d kd=%b", n_reset - r0, kd);
    key(8'hE0); key(8'hF0); key(8'h71);
    key(8'hF0); key(8'h11); key(8'hF0); key(8'h14);
    clks(1);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL ctrl_release: kd=%b expected 11111", kd); end
  endtask

  task automatic test_back_to_back;
    send_byte(8'h1A, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    send_byte(8'h36, 1'b0, 40);
    addr = 8'hFE; clks(1);
    n_checks++;
    if (kd !== 5'b11001) begin n_errors++; $display("FAIL b2b_zx: kd=%b expected 11001", kd); end
    addr = 8'hEF; clks(1);
    n_checks++;
    if (kd !== 5'b01111) begin n_errors++; $display("FAIL b2b_6: kd=%b expected 01111", kd); end
    $display("back-to-back Z X 6: kd(EF)=%b", kd);
    key(8'hF0); key(8'h1A); key(8'hF0); key(8'h22); key(8'hF0); key(8'h36);
    addr = 8'h00; clks(1);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL b2b_release: kd=%b expected 11111", kd); end
  endtask

  task automatic test_rst_mid_frame;
    int f0, m0, r0;
    key(8'h1C);
    addr = 8'hFD; clks(1);
    n_checks++;
    if (kd !== 5'b11110) begin n_errors++; $display("FAIL rst_pre: kd=%b expected 11110", kd); end
    f0 = n_ferr; m0 = n_magic; r0 = n_reset;
    ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1);
    rst = 1'b1;
    clks(3);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL rst_kd: kd=%b expected 11111", kd); end
    rst = 1'b0;
    ps2_dat = 1'b1;
    clks(2400);
    n_checks++;
    if (kd !== 5'b11111) begin n_errors++; $display("FAIL rst_kd_after: kd=%b expected 11111", kd); end
    n_checks++;
    if ((n_ferr - f0) + (n_magic - m0) + (n_reset - r0) !== 0) begin
      n_errors++; $display("FAIL rst_no_pulse: ferr=%0d magic=%0d reset=%0d expected 0", n_ferr - f0, n_magic - m0, n_reset - r0);
    end
    key(8'h1C);
    clks(1);
    n_checks++;
    if (kd !== 5'b11110) begin n_errors++; $display("FAIL rst_recover: kd=%b expected 11110", kd); end
    $display("rst mid-frame then A: kd=%b", kd);
    key(8'hF0); key(8'h1C);
  endtask

  initial begin
    test_reset();
    test_single_key();
    test_two_keys();
    test_composite();
    test_parity();
    test_timeout();
    test_magic();
    test_reset_combo();
    test_back_to_back();
    test_rst_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
